// File: rtl/bus_arbiter_n_if.sv
// Requester-port and shared-bus signals around bus_arbiter_n.
// master: the arbiter's view (it masters the shared bus); slave: the surrounding system.
interface bus_arbiter_n_if #(
  parameter int N_PORTS = 2,
  parameter int XLEN    = 32
);
  logic [N_PORTS-1:0]          i_req;
  logic [N_PORTS-1:0]          i_wen;
  logic [N_PORTS*XLEN-1:0]     i_addr;
  logic [N_PORTS*XLEN-1:0]     i_wdata;
  logic [N_PORTS*XLEN/8-1:0]   i_byte_en;
  logic [N_PORTS-1:0]          o_ready;
  logic [N_PORTS-1:0]          o_err;
  logic [XLEN-1:0]             o_rdata;
  logic [N_PORTS-1:0]          o_grant;
  logic                        i_ack;
  logic [XLEN-1:0]             i_rd_data;
  logic                        o_bus_en;
  logic                        o_wr_en;
  logic [XLEN-1:0]             o_wr_data;
  logic [XLEN-1:0]             o_addr;
  logic [XLEN/8-1:0]           o_byte_en;

  modport master (
    input  i_req, i_wen, i_addr, i_wdata, i_byte_en, i_ack, i_rd_data,
    output o_ready, o_err, o_rdata, o_grant,
    output o_bus_en, o_wr_en, o_wr_data, o_addr, o_byte_en
  );

  modport slave (
    output i_req, i_wen, i_addr, i_wdata, i_byte_en, i_ack, i_rd_data,
    input  o_ready, o_err, o_rdata, o_grant,
    input  o_bus_en, o_wr_en, o_wr_data, o_addr, o_byte_en
  );
endinterface

// File: rtl/bus_arbiter_n.sv
// N-port requester arbiter onto one shared bus master: one access in flight,
// fixed-priority or round-robin selection, optional ack timeout with error completion.
module bus_arbiter_n #(
  parameter int N_PORTS  = 2,
  parameter int XLEN     = 32,
  parameter int ARB_MODE = 0,
  parameter int TIMEOUT  = 0
) (
  input logic             i_clk,
  input logic             i_rst,
  bus_arbiter_n_if.master bus
);
  // state | meaning
  // ------+--------------------------------------------------
  // IDLE  | nothing in flight; arbitrate among i_req
  // BUSY  | bus outputs held; wait for i_ack or timeout
  // RESP  | dead cycle after o_ready; o_grant clears here

  localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int BW = XLEN / 8;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_t;

  state_t             state;
  logic [PW-1:0]      rr_ptr;
  logic [PW-1:0]      win_sel;
  logic [N_PORTS-1:0] win_oh;
  logic               win_found;
  logic               sel_wen;
  logic [XLEN-1:0]    sel_addr;
  logic [XLEN-1:0]    sel_wdata;
  logic [BW-1:0]      sel_be;
  logic [CW-1:0]      tmo_cnt;
  logic               tmo_hit;

  always_comb begin
    win_found = 1'b0;
    win_sel   = '0;
    win_oh    = '0;
    if (ARB_MODE == 1) begin
      // ports above the last winner first, then wrap round to the low indices
      for (int p = 0; p < N_PORTS; p++) begin
        if (!win_found && bus.i_req[p] && (PW'(p) > rr_ptr)) begin
          win_found = 1'b1;
          win_sel   = PW'(p);
          win_oh[p] = 1'b1;
        end
      end
      for (int p = 0; p < N_PORTS; p++) begin
        if (!win_found && bus.i_req[p] && (PW'(p) <= rr_ptr)) begin
          win_found = 1'b1;
          win_sel   = PW'(p);
          win_oh[p] = 1'b1;
        end
      end
    end else begin
      for (int p = 0; p < N_PORTS; p++) begin
        if (!win_found && bus.i_req[p]) begin
          win_found = 1'b1;
          win_sel   = PW'(p);
          win_oh[p] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_wen   = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_be    = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (win_oh[p]) begin
        sel_wen   = bus.i_wen[p];
        sel_addr  = bus.i_addr[p*XLEN +: XLEN];
        sel_wdata = bus.i_wdata[p*XLEN +: XLEN];
        sel_be    = bus.i_byte_en[p*BW +: BW];
      end
    end
  end

  // counter sits at TIMEOUT-1 on the last BUSY cycle allowed without an ack
  assign tmo_hit = (TIMEOUT > 0) && (tmo_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state         <= S_IDLE;
      rr_ptr        <= PW'(N_PORTS - 1);
      tmo_cnt       <= '0;
      bus.o_bus_en  <= 1'b0;
      bus.o_wr_en   <= 1'b0;
      bus.o_wr_data <= '0;
      bus.o_addr    <= '0;
      bus.o_byte_en <= '0;
      bus.o_rdata   <= '0;
      bus.o_ready   <= '0;
      bus.o_err     <= '0;
      bus.o_grant   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (win_found) begin
            bus.o_bus_en  <= 1'b1;
            bus.o_wr_en   <= sel_wen;
            bus.o_addr    <= sel_addr;
            bus.o_wr_data <= sel_wdata;
            bus.o_byte_en <= sel_be;
            bus.o_grant   <= win_oh;
            rr_ptr        <= win_sel;
            tmo_cnt       <= '0;
            state         <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (bus.i_ack) begin
            bus.o_rdata  <= bus.i_rd_data;
            bus.o_ready  <= bus.o_grant;
            bus.o_bus_en <= 1'b0;
            state        <= S_RESP;
          end else if (tmo_hit) begin
            bus.o_rdata  <= '0;
            bus.o_ready  <= bus.o_grant;
            bus.o_err    <= bus.o_grant;
            bus.o_bus_en <= 1'b0;
            state        <= S_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
          end
        end
        S_RESP: begin
          bus.o_ready <= '0;
          bus.o_err   <= '0;
          bus.o_grant <= '0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_arbiter_n.sv
// Bench for bus_arbiter_n: a fixed-priority instance with timeout and a round-robin
// instance without, driven from a vector table plus multi-cycle sequences.
module tb_bus_arbiter_n;
  localparam int NP = 3;
  localparam int XL = 32;
  localparam int NV = 9;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bus_arbiter_n_if #(.N_PORTS(NP), .XLEN(XL)) bif [2] ();

  bus_arbiter_n #(.N_PORTS(NP), .XLEN(XL), .ARB_MODE(0), .TIMEOUT(8)) dut_fp (
    .i_clk(clk), .i_rst(rst_n), .bus(bif[0]));
  bus_arbiter_n #(.N_PORTS(NP), .XLEN(XL), .ARB_MODE(1), .TIMEOUT(0)) dut_rr (
    .i_clk(clk), .i_rst(rst_n), .bus(bif[1]));

  typedef struct {
    int          port;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        err;
    logic        chk_rd;
    logic [31:0] rdata;
    int          lat;
    int          gap;
  } exp_t;

  typedef struct {
    int          g;
    int          port;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          delay;
    bit          noack;
    bit          spur;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  int total = 0;
  int bad   = 0;

  exp_t        exp_q [2][$];
  int          remaining [2][NP];
  logic        p_wen [2][NP];
  logic [31:0] p_addr [2][NP];
  logic [31:0] p_wdata [2][NP];
  logic [3:0]  p_be [2][NP];
  int          ack_delay [2];
  bit          ack_off [2];
  bit          spur [2];
  vec_t        vecs [NV];

  function automatic logic [31:0] bus_model(input logic [31:0] a);
    return a ^ 32'hDEADBFEF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic push_exp(input int g, input int port, input int lat, input logic err,
                          input logic chk_rd, input logic [31:0] rdata, input int gap);
    exp_t e;
    e.port   = port;
    e.wen    = p_wen[g][port];
    e.addr   = p_addr[g][port];
    e.wdata  = p_wdata[g][port];
    e.be     = p_be[g][port];
    e.err    = err;
    e.chk_rd = chk_rd;
    e.rdata  = rdata;
    e.lat    = lat;
    e.gap    = gap;
    exp_q[g].push_back(e);
  endtask

  task automatic wait_done(input int g, input int max_cyc, input string name);
    int n = 0;
    while ((exp_q[g].size() != 0 || (remaining[g][0] + remaining[g][1] + remaining[g][2]) != 0)
           && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= max_cyc) begin
      bad++;
      $display("FAIL %s: no completion within %0d cycles, %0d results pending",
               name, max_cyc, exp_q[g].size());
      exp_q[g].delete();
      for (int p = 0; p < NP; p++) remaining[g][p] = 0;
    end
  endtask

  // per-instance requester driver, bus responder and scoreboard monitor
  for (genvar g = 0; g < 2; g++) begin : g_env
    logic          prev_en;
    logic [NP-1:0] prev_rdy;
    int            cyc;
    int            rise_cyc;
    int            last_rise;
    int            wcnt;
    exp_t          e;
    logic [NP-1:0] req;
    logic [NP-1:0] oh;

    initial begin
      prev_en = 1'b0; prev_rdy = '0; cyc = 0; rise_cyc = 0; last_rise = -100; wcnt = 0;
    end

    always @(negedge clk) begin
      cyc++;
      for (int p = 0; p < NP; p++) begin
        bif[g].i_wen[p]               = p_wen[g][p];
        bif[g].i_addr[p*XL +: XL]     = p_addr[g][p];
        bif[g].i_wdata[p*XL +: XL]    = p_wdata[g][p];
        bif[g].i_byte_en[p*4 +: 4]    = p_be[g][p];
      end
      if (!rst_n) begin
        prev_en = 1'b0;
        prev_rdy = '0;
        wcnt = 0;
        bif[g].i_ack = 1'b0;
        bif[g].i_rd_data = '0;
      end else begin
        if (prev_rdy != '0) begin
          chk("ready_one_cycle", 32'(bif[g].o_ready), 32'd0);
          chk("grant_clear", 32'(bif[g].o_grant), 32'd0);
        end
        if (bif[g].o_bus_en && !prev_en) begin
          if (exp_q[g].size() == 0) begin
            chk("unexpected_grant", 32'(bif[g].o_grant), 32'd0);
          end else begin
            e = exp_q[g][0];
            oh = '0;
            oh[e.port] = 1'b1;
            chk("grant", 32'(bif[g].o_grant), 32'(oh));
            chk("bus_addr", bif[g].o_addr, e.addr);
            chk("bus_wr_en", 32'(bif[g].o_wr_en), 32'(e.wen));
            chk("bus_wr_data", bif[g].o_wr_data, e.wdata);
            chk("bus_byte_en", 32'(bif[g].o_byte_en), 32'(e.be));
            if (e.gap > 0) chk("issue_gap", cyc - last_rise, e.gap);
          end
          rise_cyc = cyc;
          last_rise = cyc;
        end
        if (bif[g].o_ready != '0) begin
          if (exp_q[g].size() == 0) begin
            chk("unexpected_ready", 32'(bif[g].o_ready), 32'd0);
          end else begin
            e = exp_q[g].pop_front();
            oh = '0;
            oh[e.port] = 1'b1;
            chk("ready", 32'(bif[g].o_ready), 32'(oh));
            chk("err", 32'(bif[g].o_err), e.err ? 32'(oh) : 32'd0);
            chk("grant_at_ready", 32'(bif[g].o_grant), 32'(oh));
            if (e.chk_rd) chk("rdata", bif[g].o_rdata, e.rdata);
            chk("latency", cyc - rise_cyc, e.lat);
          end
          for (int p = 0; p < NP; p++)
            if (bif[g].o_ready[p] && remaining[g][p] > 0) remaining[g][p]--;
        end
        if (bif[g].o_bus_en) begin
          if (!ack_off[g] && wcnt >= ack_delay[g]) begin
            bif[g].i_ack = 1'b1;
            bif[g].i_rd_data = bus_model(bif[g].o_addr);
          end else begin
            bif[g].i_ack = 1'b0;
            bif[g].i_rd_data = 32'h5A5A5A5A;
            wcnt++;
          end
        end else begin
          wcnt = 0;
          bif[g].i_ack = spur[g];
          bif[g].i_rd_data = 32'hBAD0BAD0;
        end
        prev_en = bif[g].o_bus_en;
        prev_rdy = bif[g].o_ready;
      end
      for (int p = 0; p < NP; p++) req[p] = (remaining[g][p] > 0);
      bif[g].i_req = req;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int n;
    rst_n = 1'b0;
    for (int g = 0; g < 2; g++) begin
      ack_delay[g] = 0; ack_off[g] = 1'b0; spur[g] = 1'b0;
      for (int p = 0; p < NP; p++) begin
        remaining[g][p] = 0; p_wen[g][p] = 1'b0; p_addr[g][p] = '0;
        p_wdata[g][p] = '0; p_be[g][p] = 4'hF;
      end
    end

    //          g port wen  addr          wdata         be    dly noack spur err   rdata        lat
    vecs[0] = '{0, 1, 1'b0, 32'h00000100, 32'h00000000, 4'hF, 2,  0,    0,   1'b0, 32'hDEADBEEF, 3};
    vecs[1] = '{0, 0, 1'b1, 32'h00000200, 32'h12345678, 4'h3, 0,  0,    0,   1'b0, 32'h00000000, 1};
    vecs[2] = '{0, 2, 1'b0, 32'h00000FFC, 32'h00000000, 4'hF, 5,  0,    1,   1'b0, 32'hDEADB013, 6};
    vecs[3] = '{0, 1, 1'b0, 32'h80000000, 32'h00000000, 4'hF, 7,  0,    0,   1'b0, 32'h5EADBFEF, 8};
    vecs[4] = '{0, 2, 1'b0, 32'h00000044, 32'h00000000, 4'hF, 0,  1,    0,   1'b1, 32'h00000000, 8};
    vecs[5] = '{0, 0, 1'b0, 32'h00000048, 32'h00000000, 4'hF, 0,  0,    0,   1'b0, 32'hDEADBFA7, 1};
    vecs[6] = '{1, 0, 1'b0, 32'h00000000, 32'h00000000, 4'hF, 12, 0,    0,   1'b0, 32'hDEADBFEF, 13};
    vecs[7] = '{1, 1, 1'b1, 32'h000000A0, 32'hCAFEF00D, 4'hC, 3,  0,    1,   1'b0, 32'h00000000, 4};
    vecs[8] = '{1, 2, 1'b0, 32'hFFFFFFFF, 32'h00000000, 4'h5, 1,  0,    0,   1'b0, 32'h21524010, 2};

    repeat (3) @(negedge clk);
    chk("rst_bus_en", 32'(bif[0].o_bus_en), 32'd0);
    chk("rst_wr_en", 32'(bif[0].o_wr_en), 32'd0);
    chk("rst_addr", bif[0].o_addr, 32'd0);
    chk("rst_wr_data", bif[0].o_wr_data, 32'd0);
    chk("rst_byte_en", 32'(bif[0].o_byte_en), 32'd0);
    chk("rst_rdata", bif[0].o_rdata, 32'd0);
    chk("rst_ready", 32'(bif[0].o_ready), 32'd0);
    chk("rst_err", 32'(bif[0].o_err), 32'd0);
    chk("rst_grant", 32'(bif[0].o_grant), 32'd0);
    chk("rst_rr_bus_en", 32'(bif[1].o_bus_en), 32'd0);
    chk("rst_rr_grant", 32'(bif[1].o_grant), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      p_wen[v.g][v.port]   = v.wen;
      p_addr[v.g][v.port]  = v.addr;
      p_wdata[v.g][v.port] = v.wdata;
      p_be[v.g][v.port]    = v.be;
      ack_delay[v.g] = v.delay;
      ack_off[v.g]   = v.noack;
      spur[v.g]      = v.spur;
      push_exp(v.g, v.port, v.exp_lat, v.exp_err, !v.wen || v.exp_err, v.exp_rdata, 0);
      remaining[v.g][v.port] = 1;
      wait_done(v.g, 40, $sformatf("vec%0d", i));
      spur[v.g] = 1'b0;
      ack_off[v.g] = 1'b0;
      repeat (2) @(negedge clk);
    end

    // fixed priority: port 0 keeps winning until it stops requesting
    ack_delay[0] = 0;
    p_wen[0][0] = 1'b0; p_addr[0][0] = 32'h1000; p_be[0][0] = 4'hF;
    p_wen[0][1] = 1'b0; p_addr[0][1] = 32'h2000; p_be[0][1] = 4'hF;
    for (int k = 0; k < 4; k++) push_exp(0, 0, 1, 1'b0, 1'b1, bus_model(32'h1000), (k == 0) ? 0 : 3);
    for (int k = 0; k < 2; k++) push_exp(0, 1, 1, 1'b0, 1'b1, bus_model(32'h2000), 3);
    remaining[0][0] = 4;
    remaining[0][1] = 2;
    wait_done(0, 60, "fixed_prio");
    repeat (2) @(negedge clk);

    // round-robin: last grant was port 2, so order runs 0,1,2,0,1,2
    ack_delay[1] = 0;
    for (int p = 0; p < NP; p++) begin
      p_wen[1][p] = 1'b0; p_addr[1][p] = 32'h3000 + 32'(p * 4); p_be[1][p] = 4'hF;
    end
    for (int k = 0; k < 6; k++)
      push_exp(1, k % 3, 1, 1'b0, 1'b1, bus_model(32'h3000 + 32'((k % 3) * 4)), (k == 0) ? 0 : 3);
    for (int p = 0; p < NP; p++) remaining[1][p] = 2;
    wait_done(1, 60, "round_robin");
    repeat (2) @(negedge clk);

    // reset while a port-0 write sits in BUSY
    ack_off[1] = 1'b1;
    p_wen[1][0] = 1'b1; p_addr[1][0] = 32'h300; p_wdata[1][0] = 32'h12345678; p_be[1][0] = 4'h3;
    push_exp(1, 0, 1, 1'b0, 1'b0, 32'h0, 0);
    remaining[1][0] = 1;
    n = 0;
    while (bif[1].o_bus_en !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("abort_granted", 32'(bif[1].o_bus_en), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_bus_en", 32'(bif[1].o_bus_en), 32'd0);
    chk("abort_wr_en", 32'(bif[1].o_wr_en), 32'd0);
    chk("abort_addr", bif[1].o_addr, 32'd0);
    chk("abort_wr_data", bif[1].o_wr_data, 32'd0);
    chk("abort_byte_en", 32'(bif[1].o_byte_en), 32'd0);
    chk("abort_rdata", bif[1].o_rdata, 32'd0);
    chk("abort_ready", 32'(bif[1].o_ready), 32'd0);
    chk("abort_err", 32'(bif[1].o_err), 32'd0);
    chk("abort_grant", 32'(bif[1].o_grant), 32'd0);
    exp_q[1].delete();
    p_wen[1][1] = 1'b0; p_addr[1][1] = 32'h304; p_be[1][1] = 4'hF;
    push_exp(1, 0, 1, 1'b0, 1'b0, 32'h0, 0);
    push_exp(1, 1, 1, 1'b0, 1'b1, bus_model(32'h304), 3);
    remaining[1][1] = 1;
    ack_off[1] = 1'b0;
    ack_delay[1] = 0;
    rst_n = 1'b1;
    wait_done(1, 40, "after_reset");
    repeat (3) @(negedge clk);

    chk("queues_drained", 32'(exp_q[0].size() + exp_q[1].size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
